// File: rtl/vscale_hasti_arbiter_if.sv
// One HASTI (AHB-lite) bus. A master drives the address phase and write data.
// The slave side returns read data, ready and response.
interface vscale_hasti_arbiter_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/vscale_hasti_arbiter.sv
// Two-master, one-slave HASTI arbiter. m0 (dmem) has priority and m1 (imem) has a starvation guard.
// A per-master completion buffer lets ownership move while the previous owner still requests.
//
// Handshake: a master's address phase is accepted on a rising edge where its hready is 1
// and htrans != IDLE. Its data phase completes on the next rising edge where its hready is 1.
module vscale_hasti_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    vscale_hasti_arbiter_if.slave  m0,
    vscale_hasti_arbiter_if.slave  m1,
    vscale_hasti_arbiter_if.master s
);
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} owner_e;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WAIT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    owner_e                 data_owner_q, data_owner_d;
    owner_e                 lock_owner_q, lock_owner_d;
    owner_e                 grant;
    logic [CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
    logic                   held0_q, held0_d, held1_q, held1_d;
    logic [31:0]            held0_rdata_q, held0_rdata_d, held1_rdata_q, held1_rdata_d;
    logic                   held0_resp_q, held0_resp_d, held1_resp_q, held1_resp_d;
    logic                   req0, req1, cap0, cap1, grant_lock, owner_lock;
    logic [33:0]            m0_resp, m1_resp;

    // Returns {hready, hresp, hrdata} as seen by one master.
    function automatic logic [33:0] master_resp(
        input logic        held,
        input logic [31:0] held_rdata,
        input logic        held_resp,
        input logic        owner,
        input logic        req,
        input logic        granted,
        input logic        cap,
        input logic        s_rdy,
        input logic [31:0] s_rd,
        input logic        s_rs
    );
        logic        rdy;
        logic        rs;
        logic [31:0] rd;
        rdy = 1'b1;
        rs  = 1'b0;
        rd  = 32'h0;
        if (held) begin
            rdy = granted && s_rdy;
            rs  = held_resp && rdy;
            rd  = held_rdata;
        end else if (owner) begin
            rdy = s_rdy && !cap;
            rs  = s_rs && !cap;
            rd  = s_rd;
        end else if (req) begin
            rdy = granted && s_rdy;
        end
        return {rdy, rs, rd};
    endfunction

    always_comb begin
        req0  = (m0.htrans != 2'b00);
        req1  = (m1.htrans != 2'b00);
        grant = OWN_NONE;
        if (reset)                              grant = OWN_NONE;
        else if (lock_owner_q != OWN_NONE)      grant = lock_owner_q;
        else if (req1 && wait_cnt_q >= MAX_CNT) grant = OWN_M1;
        else if (req0)                          grant = OWN_M0;
        else if (req1)                          grant = OWN_M1;
    end

    always_comb begin
        s.haddr     = 32'h0;
        s.hwrite    = 1'b0;
        s.hsize     = 3'h0;
        s.hburst    = 3'h0;
        s.hmastlock = 1'b0;
        s.hprot     = 4'h0;
        s.htrans    = 2'b00;
        grant_lock  = 1'b0;
        case (grant)
            OWN_M0: begin
                s.haddr = m0.haddr;  s.hwrite = m0.hwrite;  s.hsize = m0.hsize;
                s.hburst = m0.hburst; s.hmastlock = m0.hmastlock; s.hprot = m0.hprot;
                s.htrans = m0.htrans; grant_lock = m0.hmastlock;
            end
            OWN_M1: begin
                s.haddr = m1.haddr;  s.hwrite = m1.hwrite;  s.hsize = m1.hsize;
                s.hburst = m1.hburst; s.hmastlock = m1.hmastlock; s.hprot = m1.hprot;
                s.htrans = m1.htrans; grant_lock = m1.hmastlock;
            end
            default: ;
        endcase
        case (data_owner_q)
            OWN_M0:  s.hwdata = m0.hwdata;
            OWN_M1:  s.hwdata = m1.hwdata;
            default: s.hwdata = 32'h0;
        endcase
        case (lock_owner_q)
            OWN_M0:  owner_lock = m0.hmastlock;
            OWN_M1:  owner_lock = m1.hmastlock;
            default: owner_lock = 1'b0;
        endcase
    end

    // The data owner loses the grant while requesting again: park its completed beat.
    assign cap0 = s.hready && (data_owner_q == OWN_M0) && req0 && (grant != OWN_M0);
    assign cap1 = s.hready && (data_owner_q == OWN_M1) && req1 && (grant != OWN_M1);

    always_comb begin
        m0_resp = master_resp(held0_q, held0_rdata_q, held0_resp_q, data_owner_q == OWN_M0,
                              req0, grant == OWN_M0, cap0, s.hready, s.hrdata, s.hresp);
        m1_resp = master_resp(held1_q, held1_rdata_q, held1_resp_q, data_owner_q == OWN_M1,
                              req1, grant == OWN_M1, cap1, s.hready, s.hrdata, s.hresp);
        if (reset) begin
            m0_resp = {1'b1, 1'b0, 32'h0};
            m1_resp = {1'b1, 1'b0, 32'h0};
        end
        {m0.hready, m0.hresp, m0.hrdata} = m0_resp;
        {m1.hready, m1.hresp, m1.hrdata} = m1_resp;
    end

    always_comb begin
        data_owner_d  = data_owner_q;
        lock_owner_d  = lock_owner_q;
        wait_cnt_d    = wait_cnt_q;
        held0_d       = held0_q;
        held0_rdata_d = held0_rdata_q;
        held0_resp_d  = held0_resp_q;
        held1_d       = held1_q;
        held1_rdata_d = held1_rdata_q;
        held1_resp_d  = held1_resp_q;
        if (s.hready) begin
            data_owner_d = grant;
            if (cap0) begin
                held0_d = 1'b1; held0_rdata_d = s.hrdata; held0_resp_d = s.hresp;
            end else if (held0_q && grant == OWN_M0) begin
                held0_d = 1'b0;
            end
            if (cap1) begin
                held1_d = 1'b1; held1_rdata_d = s.hrdata; held1_resp_d = s.hresp;
            end else if (held1_q && grant == OWN_M1) begin
                held1_d = 1'b0;
            end
            if (req1 && grant != OWN_M1)
                wait_cnt_d = (wait_cnt_q >= MAX_CNT) ? MAX_CNT : wait_cnt_q + CNT_ONE;
            else
                wait_cnt_d = '0;
            if (grant != OWN_NONE && grant_lock)
                lock_owner_d = grant;
            else if (lock_owner_q != OWN_NONE && !owner_lock)
                lock_owner_d = OWN_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_owner_q  <= OWN_NONE;
            lock_owner_q  <= OWN_NONE;
            wait_cnt_q    <= '0;
            held0_q       <= 1'b0;
            held0_rdata_q <= 32'h0;
            held0_resp_q  <= 1'b0;
            held1_q       <= 1'b0;
            held1_rdata_q <= 32'h0;
            held1_resp_q  <= 1'b0;
        end else begin
            data_owner_q  <= data_owner_d;
            lock_owner_q  <= lock_owner_d;
            wait_cnt_q    <= wait_cnt_d;
            held0_q       <= held0_d;
            held0_rdata_q <= held0_rdata_d;
            held0_resp_q  <= held0_resp_d;
            held1_q       <= held1_d;
            held1_rdata_q <= held1_rdata_d;
            held1_resp_q  <= held1_resp_d;
        end
    end
endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: two scripted masters, a wait-state/error slave model,
// and per-master and slave-side scoreboards fed as stimulus is queued.
module tb_vscale_hasti_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vscale_hasti_arbiter_if m0_bus ();
  vscale_hasti_arbiter_if m1_bus ();
  vscale_hasti_arbiter_if s_bus ();

  vscale_hasti_arbiter #(.MAX_WAIT(4), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus)
  );

  localparam logic [31:0] ERR_ADDR = 32'h0000_BAD0;

  int checks = 0;
  int failures = 0;

  // command {write, addr, wdata}; master expectation {hresp, hrdata}
  logic [64:0] m0_cmd_q[$];
  logic [64:0] m1_cmd_q[$];
  logic [32:0] m0_exp_q[$];
  logic [32:0] m1_exp_q[$];
  logic [64:0] s_exp_q[$];

  logic        m0_active = 1'b0, m1_active = 1'b0;
  logic [64:0] m0_cur, m1_cur;
  logic        m0_pend = 1'b0, m1_pend = 1'b0, sd_pend = 1'b0;
  logic        sd_write = 1'b0;
  logic [31:0] sd_wdata = 32'h0;
  logic        s_chk_en = 1'b1;
  int          m0_stall = 0;
  logic        err_seen = 1'b0;

  logic        m0_rdy_s = 1'b1, m1_rdy_s = 1'b1, s_rdy_s = 1'b1;
  logic [1:0]  s_trans_s = 2'b00;
  logic [31:0] s_addr_s = 32'h0;

  int          slv_wait = 0;
  logic        dp_active = 1'b0;
  logic [31:0] dp_addr = 32'h0;
  int          wcnt = 0;
  logic        err_ph = 1'b0;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDEAD_BEEF;
      32'h0000_0040: return 32'h1234_5678;
      default:       return ~a;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input int m, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic rs, input logic [31:0] rd);
    if (m == 0) begin
      m0_cmd_q.push_back({w, a, d});
      m0_exp_q.push_back({rs, rd});
    end else begin
      m1_cmd_q.push_back({w, a, d});
      m1_exp_q.push_back({rs, rd});
    end
  endtask

  task automatic s_expect(input logic w, input logic [31:0] a, input logic [31:0] d);
    s_exp_q.push_back({w, a, d});
  endtask

  function automatic logic busy();
    return (m0_cmd_q.size() != 0) || (m1_cmd_q.size() != 0) || (m0_exp_q.size() != 0) ||
           (m1_exp_q.size() != 0) || (s_exp_q.size() != 0) || m0_active || m1_active ||
           m0_pend || m1_pend || sd_pend;
  endfunction

  task automatic wait_done(input string name, input int lim);
    int n;
    n = 0;
    while (busy() && n < lim) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (busy()) begin
      failures++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, lim);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_htrans"}, 32'(s_bus.htrans), 32'h0);
    check({tag, "_s_haddr"}, s_bus.haddr, 32'h0);
    check({tag, "_s_hwdata"}, s_bus.hwdata, 32'h0);
    check({tag, "_m0_hready"}, 32'(m0_bus.hready), 32'h1);
    check({tag, "_m1_hready"}, 32'(m1_bus.hready), 32'h1);
    check({tag, "_m0_hresp"}, 32'(m0_bus.hresp), 32'h0);
    check({tag, "_m1_hresp"}, 32'(m1_bus.hresp), 32'h0);
    check({tag, "_m0_hrdata"}, m0_bus.hrdata, 32'h0);
    check({tag, "_m1_hrdata"}, m1_bus.hrdata, 32'h0);
  endtask

  // Monitor: samples at the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [32:0] e;
    logic [64:0] se;
    m0_rdy_s  = m0_bus.hready;
    m1_rdy_s  = m1_bus.hready;
    s_rdy_s   = s_bus.hready;
    s_trans_s = s_bus.htrans;
    s_addr_s  = s_bus.haddr;
    if (reset) begin
      m0_pend = 1'b0;
      m1_pend = 1'b0;
      sd_pend = 1'b0;
    end else begin
      if (!m0_pend && m0_bus.htrans == 2'b00) check("m0_idle_hready", 32'(m0_bus.hready), 32'h1);
      if (!m1_pend && m1_bus.htrans == 2'b00) check("m1_idle_hready", 32'(m1_bus.hready), 32'h1);
      if (m0_pend && !m0_bus.hready) m0_stall++;
      if (m1_pend && !m1_bus.hready && m1_bus.hresp) err_seen = 1'b1;
      if (m0_pend && m0_bus.hready) begin
        if (m0_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL m0_resp: got unexpected completion, required none");
        end else begin
          e = m0_exp_q.pop_front();
          check("m0_hrdata", m0_bus.hrdata, e[31:0]);
          check("m0_hresp", 32'(m0_bus.hresp), 32'(e[32]));
        end
        m0_pend = 1'b0;
      end
      if (m0_bus.htrans != 2'b00 && m0_bus.hready) m0_pend = 1'b1;
      if (m1_pend && m1_bus.hready) begin
        if (m1_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL m1_resp: got unexpected completion, required none");
        end else begin
          e = m1_exp_q.pop_front();
          check("m1_hrdata", m1_bus.hrdata, e[31:0]);
          check("m1_hresp", 32'(m1_bus.hresp), 32'(e[32]));
        end
        m1_pend = 1'b0;
      end
      if (m1_bus.htrans != 2'b00 && m1_bus.hready) m1_pend = 1'b1;
      if (s_chk_en) begin
        if (sd_pend && s_bus.hready) begin
          if (sd_write) check("s_hwdata", s_bus.hwdata, sd_wdata);
          sd_pend = 1'b0;
        end
        if (s_bus.hready && s_bus.htrans != 2'b00) begin
          if (s_exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL s_haddr: got unexpected transfer 0x%08h, required none", s_bus.haddr);
          end else begin
            se = s_exp_q.pop_front();
            check("s_haddr", s_bus.haddr, se[63:32]);
            check("s_hwrite", 32'(s_bus.hwrite), 32'(se[64]));
            sd_pend  = 1'b1;
            sd_write = se[64];
            sd_wdata = se[31:0];
          end
        end
      end
    end
  end

  // Drivers: masters and slave model update just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      m0_active = 1'b0; m1_active = 1'b0; dp_active = 1'b0;
      m0_bus.htrans = 2'b00; m0_bus.haddr = 32'h0; m0_bus.hwrite = 1'b0; m0_bus.hwdata = 32'h0;
      m1_bus.htrans = 2'b00; m1_bus.haddr = 32'h0; m1_bus.hwrite = 1'b0; m1_bus.hwdata = 32'h0;
      s_bus.hready = 1'b1; s_bus.hresp = 1'b0; s_bus.hrdata = 32'h0;
    end else begin
      if (m0_rdy_s) begin
        if (m0_active) m0_bus.hwdata = m0_cur[31:0];
        if (m0_cmd_q.size() != 0) begin
          m0_cur = m0_cmd_q.pop_front();
          m0_active = 1'b1;
          m0_bus.hwrite = m0_cur[64]; m0_bus.haddr = m0_cur[63:32]; m0_bus.htrans = 2'b10;
        end else begin
          m0_active = 1'b0;
          m0_bus.hwrite = 1'b0; m0_bus.haddr = 32'h0; m0_bus.htrans = 2'b00;
        end
      end
      if (m1_rdy_s) begin
        if (m1_active) m1_bus.hwdata = m1_cur[31:0];
        if (m1_cmd_q.size() != 0) begin
          m1_cur = m1_cmd_q.pop_front();
          m1_active = 1'b1;
          m1_bus.hwrite = m1_cur[64]; m1_bus.haddr = m1_cur[63:32]; m1_bus.htrans = 2'b10;
        end else begin
          m1_active = 1'b0;
          m1_bus.hwrite = 1'b0; m1_bus.haddr = 32'h0; m1_bus.htrans = 2'b00;
        end
      end
      if (s_rdy_s) begin
        dp_active = (s_trans_s != 2'b00);
        dp_addr   = s_addr_s;
        wcnt      = slv_wait;
        err_ph    = 1'b0;
      end
      if (!dp_active) begin
        s_bus.hready = 1'b1; s_bus.hresp = 1'b0; s_bus.hrdata = 32'h0;
      end else if (dp_addr == ERR_ADDR) begin
        s_bus.hready = err_ph; s_bus.hresp = 1'b1; s_bus.hrdata = 32'h0;
        err_ph = 1'b1;
      end else if (wcnt > 0) begin
        s_bus.hready = 1'b0; s_bus.hresp = 1'b0; s_bus.hrdata = 32'h0;
        wcnt--;
      end else begin
        s_bus.hready = 1'b1; s_bus.hresp = 1'b0; s_bus.hrdata = rd_fn(dp_addr);
      end
    end
  end

  initial begin
    m0_bus.haddr = 32'h0; m0_bus.hwrite = 1'b0; m0_bus.hsize = 3'd2; m0_bus.hburst = 3'd0;
    m0_bus.hmastlock = 1'b0; m0_bus.hprot = 4'h3; m0_bus.htrans = 2'b00; m0_bus.hwdata = 32'h0;
    m1_bus.haddr = 32'h0; m1_bus.hwrite = 1'b0; m1_bus.hsize = 3'd2; m1_bus.hburst = 3'd0;
    m1_bus.hmastlock = 1'b0; m1_bus.hprot = 4'h3; m1_bus.htrans = 2'b00; m1_bus.hwdata = 32'h0;
    s_bus.hrdata = 32'h0; s_bus.hready = 1'b1; s_bus.hresp = 1'b0;

    repeat (2) @(negedge clk);
    #1 check_reset_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("after_reset");

    // m0 alone with one slave wait state
    slv_wait = 1; m0_stall = 0;
    issue(0, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 32'hDEAD_BEEF);
    s_expect(1'b0, 32'h0000_0100, 32'h0);
    wait_done("m0_alone", 50);
    check("m0_wait_cycles", 32'(m0_stall), 32'd1);
    slv_wait = 0;

    // simultaneous request: dmem first
    @(negedge clk); #1;
    issue(0, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 32'hFFFF_FDFF);
    issue(1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'hFFFF_FFFB);
    s_expect(1'b0, 32'h0000_0200, 32'h0);
    s_expect(1'b0, 32'h0000_0004, 32'h0);
    wait_done("same_cycle", 50);

    // starvation guard: m1 wins the 5th arbitration cycle, m0's 4th beat is held
    @(negedge clk); #1;
    for (int i = 0; i < 8; i++)
      issue(0, 1'b0, 32'h10 + 32'(4 * i), 32'h0, 1'b0, ~(32'h10 + 32'(4 * i)));
    issue(1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'hFFFF_FFF7);
    for (int i = 0; i < 4; i++) s_expect(1'b0, 32'h10 + 32'(4 * i), 32'h0);
    s_expect(1'b0, 32'h0000_0008, 32'h0);
    for (int i = 4; i < 8; i++) s_expect(1'b0, 32'h10 + 32'(4 * i), 32'h0);
    wait_done("starve", 100);

    // counter cleared: dmem priority restored
    @(negedge clk); #1;
    issue(0, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 32'hFFFF_FDFF);
    issue(1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'hFFFF_FFFB);
    s_expect(1'b0, 32'h0000_0200, 32'h0);
    s_expect(1'b0, 32'h0000_0004, 32'h0);
    wait_done("cnt_cleared", 50);

    // m1 streams, m0 cuts in during m1's data phase: m1 beat is held
    @(negedge clk); #1;
    issue(1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h1234_5678);
    issue(1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'hFFFF_FFBB);
    issue(1, 1'b0, 32'h0000_0048, 32'h0, 1'b0, 32'hFFFF_FFB7);
    s_expect(1'b0, 32'h0000_0040, 32'h0);
    s_expect(1'b0, 32'h0000_0500, 32'h0);
    s_expect(1'b0, 32'h0000_0044, 32'h0);
    s_expect(1'b0, 32'h0000_0048, 32'h0);
    @(negedge clk); #1;
    issue(0, 1'b0, 32'h0000_0500, 32'h0, 1'b0, 32'hFFFF_FAFF);
    wait_done("held", 50);

    // write data appears in the data phase
    @(negedge clk); #1;
    issue(0, 1'b1, 32'h0000_0300, 32'h0000_55AA, 1'b0, 32'hFFFF_FCFF);
    s_expect(1'b1, 32'h0000_0300, 32'h0000_55AA);
    wait_done("write", 50);

    // two-cycle error response to m1
    @(negedge clk); #1;
    err_seen = 1'b0;
    issue(1, 1'b0, ERR_ADDR, 32'h0, 1'b1, 32'h0);
    s_expect(1'b0, ERR_ADDR, 32'h0);
    wait_done("error", 50);
    check("m1_err_first_cycle", 32'(err_seen), 32'h1);

    // reset in the middle of contending streams
    @(negedge clk); #1;
    s_chk_en = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(0, 1'b0, 32'h600 + 32'(4 * i), 32'h0, 1'b0, ~(32'h600 + 32'(4 * i)));
    issue(1, 1'b0, 32'h0000_0700, 32'h0, 1'b0, 32'hFFFF_F8FF);
    issue(1, 1'b0, 32'h0000_0704, 32'h0, 1'b0, 32'hFFFF_F8FB);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    m0_cmd_q.delete(); m1_cmd_q.delete();
    m0_exp_q.delete(); m1_exp_q.delete(); s_exp_q.delete();
    @(negedge clk); #1;
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("mid_reset_release");
    s_chk_en = 1'b1;
    issue(0, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 32'hFFFF_FDFF);
    issue(1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'hFFFF_FFFB);
    s_expect(1'b0, 32'h0000_0200, 32'h0);
    s_expect(1'b0, 32'h0000_0004, 32'h0);
    wait_done("recover", 50);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vscale_hasti_arbiter.md
Name: vscale_hasti_arbiter

Overview:
- Two-master, one-slave AHB-lite (HASTI) arbiter.
- Lets the vscale imem and dmem bridges share one memory port, for single-ported memory configurations.
- Address and data phases stay pipelined. Fixed priority goes to dmem, with a starvation guard for imem.
- A completion buffer lets ownership switch while the previous owner is still requesting.

Parameters:
MAX_WAIT, 4, consecutive denied arbitration cycles after which m1 (imem) outranks m0 for one grant; legal range 1..15
CNT_WIDTH, 4, width of the starvation counter; must hold MAX_WAIT

Ports:
clk  input  1  core clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
m0_haddr, m1_haddr  input  32  master address (m0 = dmem bridge, m1 = imem bridge)
m0_hwrite, m1_hwrite  input  1  write enable
m0_hsize, m1_hsize  input  3  transfer size
m0_hburst, m1_hburst  input  3  burst type (SINGLE only supported)
m0_hmastlock, m1_hmastlock  input  1  locked sequence request
m0_hprot, m1_hprot  input  4  protection
m0_htrans, m1_htrans  input  2  IDLE=0, NONSEQ=2 (BUSY/SEQ treated as NONSEQ)
m0_hwdata, m1_hwdata  input  32  write data (data phase)
m0_hrdata, m1_hrdata  output  32  read data to master
m0_hready, m1_hready  output  1  per-master ready
m0_hresp, m1_hresp  output  1  per-master response (1 = ERROR)
s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans  output  32/1/3/3/1/4/2  muxed address phase to slave
s_hwdata  output  32  write data of data-phase owner
s_hrdata  input  32  slave read data
s_hready  input  1  slave ready
s_hresp  input  1  slave response

Behaviour:
- State: data_owner {NONE, M0, M1}, lock_owner {NONE, M0, M1}, wait_cnt[CNT_WIDTH], and per master: held flag, held_rdata[32], held_resp.
- Reset (sync) sets: data_owner=NONE, lock_owner=NONE, wait_cnt=0, held flags=0.
- Outputs during and after reset until a request arrives: s_htrans=0, s_haddr=0, all other s_* =0, m*_hready=1, m*_hresp=0, m*_hrdata=0.
- Request: req_i = (mi_htrans != IDLE).
- Arbitration is combinational and takes effect only when s_hready=1. Grant order:
  - lock_owner if set;
  - else M1 if req_1 and wait_cnt >= MAX_WAIT;
  - else M0 if req_0;
  - else M1 if req_1;
  - else none, and s_htrans driven IDLE.
- Address phase: s_* address-phase signals = granted master's inputs.
- Transfer accepted: on the edge where s_hready=1 and a grant exists, data_owner := grantee; with no grant, data_owner := NONE.
- s_hwdata = hwdata of data_owner; 0 when NONE.
- Normal data-owner response (not held): mX_hready = s_hready, and mX_hrdata/mX_hresp = slave values.
- A non-owner master with req=1 that is not granted sees hready=0, which extends its address phase; hresp=0.
- Idle non-owner master sees hready=1, hresp=0.
- Switch while previous owner still requests: if s_hready=1, the data_owner Y requests again, and the grant goes to the other master:
  - capture s_hrdata/s_hresp into Y's held register and set held_Y;
  - Y sees hready=0 that cycle.
- Held completion: while held_Y=1, Y sees hready=0 until Y is granted. In the grant cycle with s_hready=1, Y sees hready=1 with held_rdata/held_resp; held_Y clears on that edge.
- ERROR (two-cycle): first cycle s_hresp=1, s_hready=0 passes to data_owner; no grant change occurs since s_hready=0.
- Starvation counter:
  - wait_cnt increments (saturating at MAX_WAIT) each s_hready=1 cycle in which req_1=1 and M1 is not granted;
  - it clears when M1 is granted or req_1=0.
- Lock: lock_owner := grantee when granted with hmastlock=1. It clears on an s_hready=1 edge where the lock owner has hmastlock=0.
- Reset mid-transfer: all state clears on the next edge; any held data is discarded.

Test Plan:
- m0 alone, read 0x100 with s_hrdata=0xDEADBEEF, 1 wait state -> m0_hready low for 1 cycle, then m0_hrdata=0xDEADBEEF; m1_hready=1 throughout.
- m0 and m1 NONSEQ in the same cycle (0x200 / 0x4) -> s_haddr=0x200 first; 0x4 issued on the next s_hready cycle; m1_hready=0 until then.
- m0 streams continuously with MAX_WAIT=4 while m1 requests -> m1 granted in exactly the 5th arbitration cycle; wait_cnt returns to 0.
- m1 streaming reads, m0 requests while m1 is in data phase with s_hrdata=0x12345678 -> m1 held; later m1_hready=1 with 0x12345678 in its grant cycle.
- m0 write 0x55AA to 0x300 -> s_hwdata=0x55AA exactly in the data-phase cycle after s_haddr=0x300.
- Slave ERROR to m1 -> m1 sees hresp=1/hready=0, then hresp=1/hready=1; assert reset mid-stream -> outputs at reset values next cycle.
